// File: rtl/ysyx_24100005_regfile_pkg.sv
// Shared constants for the register file: default geometry and the
// index of the hardwired-zero register.
package ysyx_24100005_regfile_pkg;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int ZERO_REG_IDX       = 0;
endpackage

// File: rtl/ysyx_24100005_regfile_reg.sv
// Single storage register: loads din on clk when wen is set,
// and is forced to RESET_VAL asynchronously while rst is low.
module ysyx_24100005_Reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;

    assign dout_d = wen ? din : dout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dout_q <= RESET_VAL;
        else      dout_q <= dout_d;
    end

    assign dout = dout_q;
endmodule

// File: rtl/ysyx_24100005_regfile.sv
// Register file with one write port and two combinational read ports.
// Register 0 has no storage and always reads zero.
module ysyx_24100005_regfile
    import ysyx_24100005_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] rs1addr,
    input  logic [ADDR_WIDTH-1:0] rs2addr,
    output logic [DATA_WIDTH-1:0] rs1data,
    output logic [DATA_WIDTH-1:0] rs2data
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:ZERO_REG_IDX+1]    wen_vec;

    // Constant zero slot keeps the read mux uniform without a special case.
    assign regs[ZERO_REG_IDX] = '0;

    for (genvar i = ZERO_REG_IDX + 1; i < NUM_REGS; i++) begin : g_reg
        assign wen_vec[i] = wen & (waddr == ADDR_WIDTH'(i));

        ysyx_24100005_Reg #(
            .WIDTH     (DATA_WIDTH),
            .RESET_VAL ({DATA_WIDTH{1'b0}})
        ) u_reg (
            .clk  (clk),
            .rst  (rst),
            .din  (wdata),
            .dout (regs[i]),
            .wen  (wen_vec[i])
        );
    end

    // Reads see stored contents only; a same-cycle write is not forwarded.
    assign rs1data = regs[rs1addr];
    assign rs2data = regs[rs2addr];
endmodule

// File: tb/tb_ysyx_24100005_regfile.sv
// Self-checking bench: directed scenarios plus randomized traffic against
// an array model of the architectural register state.
module tb_ysyx_24100005_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rs1addr;
    logic [4:0]  rs2addr;
    logic [31:0] rs1data;
    logic [31:0] rs2data;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mdl [32];

    ysyx_24100005_regfile #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .rs1addr (rs1addr),
        .rs2addr (rs2addr),
        .rs1data (rs1data),
        .rs2data (rs2data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
    endtask

    // Architectural rule: a write lands on the edge unless disabled or aimed at x0.
    task automatic mdl_write(input logic en, input logic [4:0] a, input logic [31:0] d);
        if (en && rst && a != 5'd0) mdl[a] = d;
    endtask

    task automatic check_rd(input string tag, input logic [4:0] r1, input logic [4:0] r2);
        rs1addr = r1;
        rs2addr = r2;
        #1;
        chk({tag, "_rs1"}, rs1data, mdl[r1]);
        chk({tag, "_rs2"}, rs2data, mdl[r2]);
    endtask

    task automatic do_write(input logic en, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wen   = en;
        waddr = a;
        wdata = d;
        @(posedge clk);
        mdl_write(en, a, d);
        #1;
        wen = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; rs1addr = '0; rs2addr = '0;
        mdl_clear();

        // Reset held for two cycles with a write attempt that must be ignored.
        @(negedge clk);
        wen = 1'b1; waddr = 5'd5; wdata = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        #1;
        check_rd("in_reset", 5'd5, 5'd31);
        @(negedge clk);
        wen = 1'b0;
        rst = 1'b1;
        check_rd("rst_0", 5'd0, 5'd0);
        check_rd("rst_1", 5'd1, 5'd1);
        check_rd("rst_17", 5'd17, 5'd17);
        check_rd("rst_31", 5'd31, 5'd31);

        do_write(1'b1, 5'd5, 32'hDEADBEEF);
        check_rd("wr_x5_x6", 5'd5, 5'd6);
        chk("wr_x5_const", rs1data, 32'hDEADBEEF);

        do_write(1'b1, 5'd0, 32'h12345678);
        check_rd("x0", 5'd0, 5'd0);
        chk("x0_const", rs2data, 32'h0);

        do_write(1'b1, 5'd7, 32'h00000011);
        do_write(1'b0, 5'd7, 32'hFFFFFFFF);
        check_rd("wen0_x7", 5'd7, 5'd7);
        chk("wen0_const", rs1data, 32'h00000011);

        // Read during write: old value before the edge, new one after.
        do_write(1'b1, 5'd3, 32'h00000001);
        @(negedge clk);
        wen = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
        check_rd("rdw_pre", 5'd3, 5'd3);
        chk("rdw_pre_const", rs1data, 32'h00000001);
        @(posedge clk);
        mdl_write(1'b1, 5'd3, 32'hA5A5A5A5);
        #1;
        wen = 1'b0;
        check_rd("rdw_post", 5'd3, 5'd3);
        chk("rdw_post_const", rs2data, 32'hA5A5A5A5);

        // Async reset between edges clears the just-written x31 at once.
        do_write(1'b1, 5'd31, 32'h00000055);
        @(negedge clk);
        #1;
        rst = 1'b0;
        mdl_clear();
        check_rd("async_rst", 5'd31, 5'd3);
        chk("async_rst_const", rs1data, 32'h0);
        #1;
        rst = 1'b1;

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(39) == 0) begin
                @(negedge clk);
                #1;
                rst = 1'b0;
                mdl_clear();
                check_rd("rnd_rst", 5'($urandom_range(31)), 5'($urandom_range(31)));
                #1;
                rst = 1'b1;
            end else begin
                do_write($urandom_range(4) != 0, 5'($urandom_range(31)), 32'($urandom));
                if ($urandom_range(3) == 0) check_rd("rnd_same", waddr, waddr);
                else check_rd("rnd", 5'($urandom_range(31)), 5'($urandom_range(31)));
            end
        end

        for (int i = 0; i < 32; i++) check_rd("sweep", 5'(i), 5'(31 - i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
